// File: rtl/video_composite_timing.sv
// NTSC-style composite raster timing generator: 240p by default, 480i when
// VIDEO_TIMING_INTERLACE_EN is defined. All outputs are registered and aligned with h_cnt/v_cnt.
module video_composite_timing #(
  parameter int H_TOTAL     = 1588,
  parameter int H_SYNC      = 117,
  parameter int EQ_W        = 58,
  parameter int SERR_W      = 117,
  parameter int BURST_START = 133,
  parameter int BURST_LEN   = 56,
  parameter int H_ACT_START = 250,
  parameter int H_ACTIVE    = 1280,
  parameter int V_TOTAL     = 262,
  parameter int V_ACT_START = 21,
  parameter int V_ACTIVE    = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] h_cnt,
  output logic [8:0]  v_cnt,
  output logic        sync_n,
  output logic        color_burst,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        field
);

  localparam int HALF = H_TOTAL / 2;

  if (H_ACT_START + H_ACTIVE > H_TOTAL || V_ACT_START + V_ACTIVE > V_TOTAL ||
      V_ACT_START < 9 || H_TOTAL > 2048 || V_TOTAL + 1 > 512 ||
      SERR_W > HALF || HALF + EQ_W > H_TOTAL) begin : g_param_check
    $error("video_composite_timing: illegal timing parameters");
  end

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] EQ_END       = 11'(EQ_W);
  localparam logic [10:0] HALF_POS     = 11'(HALF);
  localparam logic [10:0] HALF_EQ_END  = 11'(HALF + EQ_W);
  localparam logic [10:0] SERR1_START  = 11'(HALF - SERR_W);
  localparam logic [10:0] SERR2_START  = 11'(H_TOTAL - SERR_W);
  localparam logic [10:0] HSYNC_END    = 11'(H_SYNC);
  localparam logic [10:0] BURST_S      = 11'(BURST_START);
  localparam logic [10:0] BURST_E      = 11'(BURST_START + BURST_LEN);
  localparam logic [10:0] ACT_S        = 11'(H_ACT_START);
  localparam logic [10:0] ACT_E        = 11'(H_ACT_START + H_ACTIVE);
  localparam logic [8:0]  V_LAST       = 9'(V_TOTAL - 1);
  localparam logic [8:0]  VACT_S       = 9'(V_ACT_START);
  localparam logic [8:0]  VACT_E       = 9'(V_ACT_START + V_ACTIVE);

  typedef enum logic [1:0] {
    REG_EQ,
    REG_VSYNC,
    REG_NORMAL
  } v_region_e;

  logic [10:0] h_nxt;
  logic [8:0]  v_nxt;
  logic [8:0]  v_last_line;
  logic        h_last;
  logic        v_last;
  logic        field_nxt;
  logic        running;
  logic        running_nxt;
  logic        sync_low;
  logic        suppress_eq0;
  v_region_e   region;

  // Everything is decoded from the next counter values so that the registered
  // outputs land in the same cycle as the counters they describe.
  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    h_last       = (h_cnt == H_LAST);
`ifdef VIDEO_TIMING_INTERLACE_EN
    v_last_line  = field ? 9'(V_TOTAL) : V_LAST;
`else
    v_last_line  = V_LAST;
`endif
    v_last       = (v_cnt == v_last_line);
    h_nxt        = h_last ? 11'd0 : h_cnt + 11'd1;
    v_nxt        = v_cnt;
    field_nxt    = 1'b0;
    if (h_last) v_nxt = v_last ? 9'd0 : v_cnt + 9'd1;
`ifdef VIDEO_TIMING_INTERLACE_EN
    field_nxt    = (h_last && v_last) ? ~field : field;
`endif
    // Outputs stay blanked for the partial line that follows reset.
    running_nxt  = running | h_last;
    suppress_eq0 = field_nxt && (v_nxt == 9'd0);

    region = REG_NORMAL;
    if (v_nxt < 9'd3)      region = REG_EQ;
    else if (v_nxt < 9'd6) region = REG_VSYNC;
    else if (v_nxt < 9'd9) region = REG_EQ;

    sync_low = 1'b0;
    unique case (region)
      REG_EQ:     sync_low = ((h_nxt < EQ_END) && !suppress_eq0) ||
                             ((h_nxt >= HALF_POS) && (h_nxt < HALF_EQ_END));
      REG_VSYNC:  sync_low = !(((h_nxt >= SERR1_START) && (h_nxt < HALF_POS)) ||
                               (h_nxt >= SERR2_START));
      REG_NORMAL: sync_low = (h_nxt < HSYNC_END);
      default:    sync_low = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      sync_n      <= 1'b1;
      color_burst <= 1'b0;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      field       <= 1'b0;
      running     <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      field       <= field_nxt;
      running     <= running_nxt;
      sync_n      <= !(running_nxt && sync_low);
      color_burst <= running_nxt && (region == REG_NORMAL) &&
                     (h_nxt >= BURST_S) && (h_nxt < BURST_E);
      active      <= running_nxt && (h_nxt >= ACT_S) && (h_nxt < ACT_E) &&
                     (v_nxt >= VACT_S) && (v_nxt < VACT_E);
      line_start  <= (h_nxt == 11'd0);
      frame_start <= (h_nxt == 11'd0) && (v_nxt == 9'd0);
    end
  end

endmodule
